// File: rtl/fdc_avr_master.sv
// Single-outstanding master for the FDC CPLD's strobed AVR-style bus, plus
// synchronization and rising-edge detection of the CPLD's attention flags.
module fdc_avr_master #(
    parameter int SETUP_CYC = 2,
    parameter int SEL_CYC   = 12,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 4
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] a_addrbus,
    inout  wire  [7:0]  a_databus,
    output logic        a_rw,
    output logic        a_sel,
    input  logic [1:0]  intr,
    output logic [1:0]  irq_event
);

    localparam logic [7:0] LD_SETUP = 8'(SETUP_CYC - 1);
    localparam logic [7:0] LD_SEL   = 8'(SEL_CYC - 1);
    localparam logic [7:0] LD_HOLD  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] LD_GAP   = 8'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  wdata_q;
    logic        drive_en;
    logic [1:0]  sync_p0;
    logic [1:0]  sync_p1;
    logic [1:0]  sync_p2;

    // drive_en is reset asynchronously, so an aborted write releases the bus at once
    assign a_databus = drive_en ? wdata_q : 8'hzz;

    always_ff @(posedge clock_50) begin
        if (state == IDLE && cmd_valid)
            wdata_q <= cmd_wdata;
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            a_sel     <= 1'b1;
            a_rw      <= 1'b1;
            a_addrbus <= 16'h0000;
            drive_en  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= SETUP;
                        cnt       <= LD_SETUP;
                        cmd_ready <= 1'b0;
                        a_rw      <= cmd_rw;
                        a_addrbus <= cmd_addr;
                        drive_en  <= ~cmd_rw;
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        state <= STROBE;
                        cnt   <= LD_SEL;
                        a_sel <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                STROBE: begin
                    // read data is sampled on the edge that releases a_sel
                    if (cnt == 8'd0) begin
                        state <= HOLD;
                        cnt   <= LD_HOLD;
                        a_sel <= 1'b1;
                        if (a_rw)
                            rsp_rdata <= a_databus;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        state     <= GAP;
                        cnt       <= LD_GAP;
                        drive_en  <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 8'd0) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        a_rw      <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 8'd0;
                    cmd_ready <= 1'b1;
                    a_sel     <= 1'b1;
                    a_rw      <= 1'b1;
                    drive_en  <= 1'b0;
                end
            endcase
        end
    end

    // two synchronizer flops, then a third flop for rising-edge detection
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0   <= 2'b00;
            sync_p1   <= 2'b00;
            sync_p2   <= 2'b00;
            irq_event <= 2'b00;
        end else begin
            sync_p0   <= intr;
            sync_p1   <= sync_p0;
            sync_p2   <= sync_p1;
            irq_event <= sync_p1 & ~sync_p2;
        end
    end

endmodule

// File: tb/tb_fdc_avr_master.sv
`timescale 1ns/1ps
// Randomized bench for fdc_avr_master: a default-timing and a minimum-timing instance
// compared every cycle against a phase-arithmetic reference model.
module tb_fdc_avr_master;

    localparam int NI   = 2;
    localparam int NCYC = 1600;

    function automatic int p_s(input int i);   return (i == 0) ? 2 : 1;  endfunction
    function automatic int p_l(input int i);   return (i == 0) ? 12 : 8; endfunction
    function automatic int p_h(input int i);   return (i == 0) ? 2 : 1;  endfunction
    function automatic int p_g(input int i);   return (i == 0) ? 4 : 3;  endfunction
    function automatic int p_tot(input int i); return p_s(i) + p_l(i) + p_h(i) + p_g(i); endfunction

    logic        clock_50 = 1'b0;
    logic        reset_n;
    logic [1:0]  intr;
    logic        cmd_valid [NI];
    logic        cmd_rw    [NI];
    logic [15:0] cmd_addr  [NI];
    logic [7:0]  cmd_wdata [NI];
    logic        cmd_ready [NI];
    logic        rsp_valid [NI];
    logic [7:0]  rsp_rdata [NI];
    logic [15:0] a_addrbus [NI];
    logic        a_rw      [NI];
    logic        a_sel     [NI];
    logic [1:0]  irq_event [NI];
    wire  [7:0]  bus0;
    wire  [7:0]  bus1;
    logic [7:0]  bus_v     [NI];

    logic        tb_drv    [NI];
    logic [7:0]  tb_rdata  [NI];
    logic [7:0]  tb_probe  [NI];

    // bus model: returns read data during a read strobe, a probe value otherwise
    assign bus0 = tb_drv[0] ? ((!a_sel[0] && a_rw[0]) ? tb_rdata[0] : tb_probe[0]) : 8'hzz;
    assign bus1 = tb_drv[1] ? ((!a_sel[1] && a_rw[1]) ? tb_rdata[1] : tb_probe[1]) : 8'hzz;
    assign bus_v[0] = bus0;
    assign bus_v[1] = bus1;

    always #5 clock_50 = ~clock_50;

    fdc_avr_master u_dut0 (
        .clock_50(clock_50), .reset_n(reset_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_rw(cmd_rw[0]),
        .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .a_addrbus(a_addrbus[0]), .a_databus(bus0), .a_rw(a_rw[0]), .a_sel(a_sel[0]),
        .intr(intr), .irq_event(irq_event[0])
    );

    fdc_avr_master #(.SETUP_CYC(1), .SEL_CYC(8), .HOLD_CYC(1), .GAP_CYC(3)) u_dut1 (
        .clock_50(clock_50), .reset_n(reset_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_rw(cmd_rw[1]),
        .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .a_addrbus(a_addrbus[1]), .a_databus(bus1), .a_rw(a_rw[1]), .a_sel(a_sel[1]),
        .intr(intr), .irq_event(irq_event[1])
    );

    // reference model state
    bit          m_busy   [NI];
    int          m_n      [NI];
    logic        m_rw     [NI];
    logic [15:0] m_addr   [NI];
    logic [7:0]  m_wdata  [NI];
    logic [7:0]  m_rsp    [NI];
    logic [1:0]  hist     [4];

    int          ncmd       [NI];
    logic [7:0]  pend_rdata [NI];
    logic [7:0]  pend_probe [NI];
    bit          btb        [NI];
    int          last_acc   [NI];
    int          hi_run     [NI];
    int          lo_run     [NI];
    bit          seen_lo    [NI];
    int          cyc;
    int          n_checks;
    int          n_fail;
    bit          rst_done;
    bit          rst_hold;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic new_cmd(input int i);
        int k;
        k = ncmd[i];
        ncmd[i] = k + 1;
        cmd_valid[i]  = 1'b1;
        cmd_rw[i]     = 1'($urandom_range(0, 1));
        cmd_addr[i]   = 16'($urandom);
        cmd_wdata[i]  = 8'($urandom_range(1, 255));
        pend_rdata[i] = 8'($urandom);
        if (i == 0 && k == 0) begin
            cmd_rw[i] = 1'b0; cmd_addr[i] = 16'h1234; cmd_wdata[i] = 8'h5A;
        end else if (i == 0 && k == 1) begin
            cmd_rw[i] = 1'b1; cmd_addr[i] = 16'h0011; pend_rdata[i] = 8'hA5;
        end else if (i == 1 && k == 0) begin
            cmd_rw[i] = 1'b1; cmd_addr[i] = 16'hBEEF; pend_rdata[i] = 8'h3C;
        end
        pend_probe[i] = 8'($urandom);
        if (pend_probe[i] == pend_rdata[i])
            pend_probe[i] = ~pend_rdata[i];
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 1'b0; m_n[i] = 0; m_rw[i] = 1'b1;
            m_addr[i] = 16'h0000; m_wdata[i] = 8'h00; m_rsp[i] = 8'h00;
            tb_drv[i] = 1'b1; btb[i] = 1'b0;
            hi_run[i] = 0; lo_run[i] = 0; seen_lo[i] = 1'b0;
        end
        for (int k = 0; k < 4; k++) hist[k] = 2'b00;
    endtask

    task automatic model_step();
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = reset_n ? intr : 2'b00;
        if (reset_n) begin
            for (int i = 0; i < NI; i++) begin
                if (m_busy[i]) begin
                    m_n[i]++;
                    if (m_rw[i] && m_n[i] == p_s(i) + p_l(i) + 1) m_rsp[i] = tb_rdata[i];
                    if (m_n[i] > p_tot(i)) m_busy[i] = 1'b0;
                end else if (cmd_valid[i]) begin
                    m_busy[i] = 1'b1; m_n[i] = 1;
                    m_rw[i] = cmd_rw[i]; m_addr[i] = cmd_addr[i]; m_wdata[i] = cmd_wdata[i];
                    tb_rdata[i] = pend_rdata[i]; tb_probe[i] = pend_probe[i];
                    if ((i == 0 && ncmd[0] == 1) || $urandom_range(0, 2) == 0) begin
                        new_cmd(i);
                        btb[i] = 1'b1;
                    end else begin
                        cmd_valid[i] = 1'b0;
                        btb[i] = 1'b0;
                    end
                end
                tb_drv[i] = !(m_busy[i] && !m_rw[i] && m_n[i] <= p_s(i) + p_l(i) + p_h(i));
            end
        end
    endtask

    task automatic check_outputs();
        logic [1:0] exp_irq;
        exp_irq = hist[2] & ~hist[3];
        for (int i = 0; i < NI; i++) begin
            bit         strobe;
            logic       exp_rw;
            logic [7:0] exp_bus;
            int         min_hi;
            strobe  = m_busy[i] && m_n[i] > p_s(i) && m_n[i] <= p_s(i) + p_l(i);
            exp_rw  = m_busy[i] ? m_rw[i] : 1'b1;
            exp_bus = tb_drv[i] ? ((strobe && exp_rw) ? tb_rdata[i] : tb_probe[i]) : m_wdata[i];
            check_eq($sformatf("a_sel%0d", i),     32'(a_sel[i]),     32'(!strobe));
            check_eq($sformatf("a_rw%0d", i),      32'(a_rw[i]),      32'(exp_rw));
            check_eq($sformatf("a_addrbus%0d", i), 32'(a_addrbus[i]), 32'(m_addr[i]));
            check_eq($sformatf("cmd_ready%0d", i), 32'(cmd_ready[i]), 32'(!m_busy[i]));
            check_eq($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]),
                     32'(m_busy[i] && m_n[i] == p_s(i) + p_l(i) + p_h(i) + 1));
            check_eq($sformatf("rsp_rdata%0d", i), 32'(rsp_rdata[i]), 32'(m_rsp[i]));
            check_eq($sformatf("a_databus%0d", i), 32'(bus_v[i]),     32'(exp_bus));
            check_eq($sformatf("irq_event%0d", i), 32'(irq_event[i]), 32'(exp_irq));
            min_hi = p_g(i) + 1;
            if (!a_sel[i]) begin
                if (lo_run[i] == 0 && seen_lo[i])
                    check_eq($sformatf("sel_gap%0d", i),
                             32'((hi_run[i] >= min_hi) ? min_hi : hi_run[i]), 32'(min_hi));
                lo_run[i]++; hi_run[i] = 0; seen_lo[i] = 1'b1;
            end else begin
                if (lo_run[i] > 0)
                    check_eq($sformatf("sel_low_len%0d", i), 32'(lo_run[i]), 32'(p_l(i)));
                lo_run[i] = 0; hi_run[i]++;
            end
            if (reset_n && cmd_valid[i] && cmd_ready[i]) begin
                if (btb[i])
                    check_eq($sformatf("b2b_accept%0d", i), 32'(cyc - last_acc[i]), 32'(p_tot(i) + 1));
                last_acc[i] = cyc;
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        rst_done = 1'b0; rst_hold = 1'b0;
        reset_n = 1'b0; intr = 2'b00;
        for (int i = 0; i < NI; i++) begin
            cmd_valid[i] = 1'b0; cmd_rw[i] = 1'b0; cmd_addr[i] = 16'h0; cmd_wdata[i] = 8'h0;
            ncmd[i] = 0; pend_rdata[i] = 8'h00; pend_probe[i] = 8'h69;
            tb_rdata[i] = 8'h00; tb_probe[i] = 8'h69; last_acc[i] = 0;
        end
        model_reset();
        repeat (3) @(posedge clock_50);
        @(negedge clock_50);
        check_outputs();
        reset_n = 1'b1;
        new_cmd(0);
        new_cmd(1);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clock_50);
            #1;
            model_step();
            @(negedge clock_50);
            cyc++;
            check_outputs();
            if (rst_hold) begin
                reset_n = 1'b1;
                rst_hold = 1'b0;
            end else if (!rst_done && ncmd[0] >= 4 && m_busy[0] && !m_rw[0] &&
                         m_n[0] == p_s(0) + 5) begin
                reset_n = 1'b0;
                model_reset();
                rst_done = 1'b1;
                rst_hold = 1'b1;
                #1;
                check_outputs();
            end
            if (cyc == 5)                                    intr = 2'b11;
            else if (cyc == 15)                              intr = 2'b01;
            else if (cyc == 25)                              intr = 2'b11;
            else if (cyc > 40 && $urandom_range(0, 3) == 0)  intr = 2'($urandom);
            for (int i = 0; i < NI; i++)
                if (reset_n && !cmd_valid[i] && $urandom_range(0, 3) == 0) new_cmd(i);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fdc_avr_master.md
FDC_AVR_MASTER -- requirements
Module: fdc_avr_master

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles a_addrbus/a_rw/a_databus are stable with a_sel high before strobe; legal 1-255.
REQ-002 Parameter SEL_CYC, default 12: cycles a_sel is held low; legal 8-255.
REQ-003 Parameter HOLD_CYC, default 2: cycles address/data are held after a_sel returns high; legal 1-255.
REQ-004 Parameter GAP_CYC, default 4: minimum a_sel-high idle cycles between strobes; legal 3-255.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clock_50  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  transaction request
- cmd_ready  out  1  block can accept a request
- cmd_rw  in  1  1 = read, 0 = write
- cmd_addr  in  16  target address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle transaction-complete pulse
- rsp_rdata  out  8  captured read data
- a_addrbus  out  16  bus address
- a_databus  inout  8  bus data; driven by this block only during writes
- a_rw  out  1  bus direction, 1 = read
- a_sel  out  1  active-low bus strobe
- intr  in  2  asynchronous attention flags from the FDC CPLD
- irq_event  out  2  one-cycle pulse per rising edge of synchronized intr

Function
REQ-006 A request SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1, and cmd_rw/cmd_addr/cmd_wdata SHALL be latched on that edge.
REQ-007 cmd_ready SHALL be 1 only in state IDLE.
REQ-008 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD and GAP, and SHALL transition IDLE->SETUP on accept.
REQ-009 SETUP->STROBE SHALL occur after SETUP_CYC cycles, STROBE->HOLD after SEL_CYC cycles, HOLD->GAP after HOLD_CYC cycles, and GAP->IDLE after GAP_CYC cycles.
REQ-010 a_sel SHALL be 0 exactly in STROBE and 1 in all other states.
REQ-011 a_addrbus and a_rw SHALL present the latched values in SETUP, STROBE and HOLD, and SHALL keep their last values in GAP and IDLE.
REQ-012 In IDLE, a_rw SHALL be 1.
REQ-013 a_databus SHALL be driven with latched wdata only in SETUP, STROBE and HOLD of a write, and SHALL be high-Z at all other times.
REQ-014 On a read, rsp_rdata SHALL capture a_databus on the edge ending the last STROBE cycle, i.e. while a_sel is still low.
REQ-015 rsp_rdata SHALL be unchanged by writes.
REQ-016 rsp_valid SHALL be 1 for exactly the first GAP cycle; latency from the accept edge to rsp_valid high SHALL be SETUP_CYC+SEL_CYC+HOLD_CYC+1 cycles, i.e. 17 with defaults.
REQ-017 cmd_valid while busy SHALL be ignored, with no queuing; the requester SHALL hold cmd_valid until cmd_ready is 1.
REQ-018 A single 8-bit down-counter SHALL time all phases; it SHALL load (N-1) on state entry and transition at 0, so no wrap-around occurs.
REQ-019 intr SHALL pass through a 2-flop synchronizer per bit; irq_event[i] SHALL be 1 for one cycle when the synchronized bit goes 0->1.
REQ-020 Simultaneous rising edges on both intr bits SHALL pulse both irq_event bits in the same cycle.
REQ-021 intr handling SHALL be independent of FSM state.
REQ-022 Back-to-back requests SHALL be separated by at least GAP_CYC+1 cycles of a_sel=1, so that a 3-stage target synchronizer always sees a fresh falling edge.

Reset
REQ-023 While reset_n=0, outputs SHALL be: state IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=8'h00, a_sel=1, a_rw=1, a_addrbus=16'h0000, a_databus high-Z, irq_event=2'b00, synchronizers and counter cleared.
REQ-024 Reset asserted mid-transaction SHALL abort it immediately (asynchronously): a_sel=1, a_databus released, and no rsp_valid is ever issued for the aborted request.
REQ-025 After reset_n deasserts, the first accept SHALL be possible on the next rising edge.

Verification
REQ-026 Write 0x5A to 0x1234 (defaults) -> a_sel low for exactly 12 cycles, a_databus=0x5A from SETUP through HOLD, rsp_valid 17 cycles after accept, then a_databus high-Z.
REQ-027 Read 0x0011 with bus model driving 0xA5 while a_rw=1 and a_sel=0 -> rsp_rdata=0xA5 at rsp_valid; a_databus is never driven by the DUT.
REQ-028 Two requests with cmd_valid held high -> second accepted 21 cycles after first, with a_sel high for at least 7 cycles between strobes.
REQ-029 Reset pulsed during cycle 5 of STROBE -> a_sel=1 and a_databus high-Z within the reset cycle, no rsp_valid, and the next request completes normally.
REQ-030 intr 00->11, held, ->01->11 -> irq_event=11 once (2-3 cycles later), then irq_event=10 once, with no pulse on the falling transition.
REQ-031 Parameters SETUP_CYC=1, SEL_CYC=8, HOLD_CYC=1, GAP_CYC=3 -> read latency 11 cycles and a_sel low for exactly 8 cycles.
